line_pack_arbiter: RTL and testbench

- Parametrised successor to the single-line stage-3 packing path.
- Accepts a stream of per-beat compressed chunks (variable bit length) plus the matching raw words over a valid/ready handshake.
- Packs the chunks LSB-first into one cache-line result.
- At line end, emits either the packed compressed line or, on overflow, the raw backup line, through a registered output slot with backpressure.

---
 rtl/line_pack_pkg.sv | 37 +++
 rtl/bit_appender.sv | 31 +++
 rtl/line_pack_arbiter.sv | 173 +++++++++++++++++
 tb/tb_line_pack_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pack_pkg.sv
// Shared defaults, derived-width helpers and output record for the line packing blocks.
package line_pack_pkg;

    localparam int DEF_RAW_WIDTH  = 64;
    localparam int DEF_LINE_WIDTH = 128;
    localparam int DEF_CDATA_W    = 68;

    // Number of raw beats that make up one cache line.
    function automatic int calc_beats(input int line_width, input int raw_width);
        return line_width / raw_width;
    endfunction

    // Width that holds the largest possible sum of compressed lengths in one line.
    function automatic int calc_len_w(input int beats, input int cdata_w);
        return $clog2(beats * cdata_w + 1);
    endfunction

    // Beat counter width; a single-beat line still gets a one-bit counter.
    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEF_BEATS = calc_beats(DEF_LINE_WIDTH, DEF_RAW_WIDTH);
    localparam int DEF_LEN_W = calc_len_w(DEF_BEATS, DEF_CDATA_W);

    // Line collection states: COLLECT while earlier beats arrive, CLOSE on the last beat.
    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_CLOSE   = 1'b1;

    // Output record at the default geometry, for consumers of the standard configuration.
    typedef struct packed {
        logic [DEF_LINE_WIDTH-1:0] line;
        logic                      comp;
        logic [DEF_LEN_W-1:0]      len;
    } out_line_t;

endpackage

// File: rtl/bit_appender.sv
// Combinational LSB-first bit packer: masks a chunk to its length and ORs it in at the current fill point.
module bit_appender #(
    parameter int ACC_W   = 196,
    parameter int LEN_W   = 8,
    parameter int CDATA_W = 68,
    parameter int CLEN_W  = 7
) (
    input  logic [ACC_W-1:0]   i_acc,
    input  logic [LEN_W-1:0]   i_total,
    input  logic [CDATA_W-1:0] i_cdata,
    input  logic [CLEN_W-1:0]  i_clen,
    output logic [ACC_W-1:0]   o_acc,
    output logic [LEN_W-1:0]   o_total
);

    logic [CDATA_W-1:0] masked;
    logic [ACC_W-1:0]   widened;

    // Drop every chunk bit at or above the declared length so stray upper bits never leak in.
    always_comb begin
        masked = '0;
        for (int i = 0; i < CDATA_W; i++) begin
            masked[i] = i_cdata[i] & (i < int'(i_clen));
        end
    end

    assign widened = ACC_W'(masked);
    assign o_acc   = i_acc | (widened << i_total);
    assign o_total = i_total + LEN_W'(i_clen);

endmodule

// File: rtl/line_pack_arbiter.sv
// Packs per-beat compressed chunks into one cache line and emits either the packed
// line or, when the chunks do not fit, the raw backup line through a registered slot.
module line_pack_arbiter
    import line_pack_pkg::*;
#(
    parameter int  RAW_WIDTH  = DEF_RAW_WIDTH,
    parameter int  LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int  CDATA_W    = DEF_CDATA_W,
    localparam int BEATS      = calc_beats(LINE_WIDTH, RAW_WIDTH),
    localparam int LEN_W      = calc_len_w(BEATS, CDATA_W),
    localparam int CLEN_W     = $clog2(CDATA_W + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CDATA_W-1:0]    i_cdata,
    input  logic [CLEN_W-1:0]     i_clen,
    input  logic [RAW_WIDTH-1:0]  i_raw,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LINE_WIDTH-1:0] o_line,
    output logic                  o_comp,
    output logic [LEN_W-1:0]      o_len
);

    localparam int               ACC_W       = LINE_WIDTH + CDATA_W;
    localparam int               CNT_W       = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [LEN_W-1:0] LINE_LEN    = LEN_W'(LINE_WIDTH);
    localparam logic             RESET_STATE = (BEATS == 1) ? ST_CLOSE : ST_COLLECT;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] line;
        logic                  comp;
        logic [LEN_W-1:0]      len;
    } slot_t;

    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  state_q, state_d;
    logic [LEN_W-1:0]      total_q, total_d;
    logic                  overflow_q, overflow_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [LINE_WIDTH-1:0] raw_buf_q, raw_buf_d;
    slot_t                 slot_q, slot_d;
    logic                  out_valid_q, out_valid_d;

    logic [ACC_W-1:0]      app_acc;
    logic [LEN_W-1:0]      app_total;
    logic [ACC_W-1:0]      line_acc;
    logic [LEN_W-1:0]      line_total;
    logic                  line_over;
    logic                  load_line;
    logic                  accept;

    bit_appender #(
        .ACC_W   (ACC_W),
        .LEN_W   (LEN_W),
        .CDATA_W (CDATA_W),
        .CLEN_W  (CLEN_W)
    ) u_appender (
        .i_acc   (acc_q),
        .i_total (total_q),
        .i_cdata (i_cdata),
        .i_clen  (i_clen),
        .o_acc   (app_acc),
        .o_total (app_total)
    );

    // Only the closing beat can stall, and only while a full slot is not being drained.
    assign o_ready = !i_flush && (state_q != ST_CLOSE || !out_valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    // Per-line collection: append chunks until overflow, capture raw words, close on the last beat.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        state_d    = state_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        acc_d      = acc_q;
        raw_buf_d  = raw_buf_q;
        line_acc   = acc_q;
        line_total = total_q;
        line_over  = overflow_q;
        load_line  = 1'b0;
        if (i_flush) begin
            beat_cnt_d = '0;
            state_d    = RESET_STATE;
            total_d    = '0;
            overflow_d = 1'b0;
            acc_d      = '0;
            raw_buf_d  = '0;
        end else if (accept) begin
            raw_buf_d[int'(beat_cnt_q) * RAW_WIDTH +: RAW_WIDTH] = i_raw;
            if (!overflow_q) begin
                line_acc   = app_acc;
                line_total = app_total;
                line_over  = (app_total > LINE_LEN);
            end
            if (state_q == ST_CLOSE) begin
                load_line  = 1'b1;
                beat_cnt_d = '0;
                state_d    = RESET_STATE;
                total_d    = '0;
                overflow_d = 1'b0;
                acc_d      = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                state_d    = (beat_cnt_d == LAST_BEAT) ? ST_CLOSE : ST_COLLECT;
                total_d    = line_total;
                overflow_d = line_over;
                acc_d      = line_acc;
            end
        end
    end

    // Output slot: load a finished line (possibly while the old one drains), otherwise hold or empty.
    always_comb begin
        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        if (load_line) begin
            out_valid_d = 1'b1;
            if (line_over) begin
                slot_d.line = raw_buf_d;
                slot_d.comp = 1'b0;
                slot_d.len  = LINE_LEN;
            end else begin
                slot_d.line = line_acc[LINE_WIDTH-1:0];
                slot_d.comp = 1'b1;
                slot_d.len  = line_total;
            end
        end else if (out_valid_q && i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Line collection registers; a reset mid-line discards the partial line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            beat_cnt_q <= '0;
            state_q    <= RESET_STATE;
            total_q    <= '0;
            overflow_q <= 1'b0;
            acc_q      <= '0;
            raw_buf_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            state_q    <= state_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
            raw_buf_q  <= raw_buf_d;
        end
    end

    // Output slot registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            slot_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_line  = slot_q.line;
    assign o_comp  = slot_q.comp;
    assign o_len   = slot_q.len;

endmodule

// File: tb/tb_line_pack_arbiter.sv
// Self-checking bench for line_pack_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a line-level behavioural model.
module tb_line_pack_arbiter;

    localparam int RAW_WIDTH  = 64;
    localparam int LINE_WIDTH = 128;
    localparam int CDATA_W    = 68;
    localparam int BEATS      = 2;
    localparam int LEN_W      = 8;
    localparam int CLEN_W     = 7;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic                  i_valid;
    logic                  o_ready;
    logic [CDATA_W-1:0]    i_cdata;
    logic [CLEN_W-1:0]     i_clen;
    logic [RAW_WIDTH-1:0]  i_raw;
    logic                  i_flush;
    logic                  o_valid;
    logic                  i_ready;
    logic [LINE_WIDTH-1:0] o_line;
    logic                  o_comp;
    logic [LEN_W-1:0]      o_len;

    line_pack_arbiter #(
        .RAW_WIDTH  (RAW_WIDTH),
        .LINE_WIDTH (LINE_WIDTH),
        .CDATA_W    (CDATA_W)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_cdata (i_cdata),
        .i_clen  (i_clen),
        .i_raw   (i_raw),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_line  (o_line),
        .o_comp  (o_comp),
        .o_len   (o_len)
    );

    always #5 clk = ~clk;

    // Behavioural model: the beats of the line in progress and the expected output slot.
    int                    m_cnt;
    logic [CDATA_W-1:0]    m_cdata [BEATS];
    int                    m_clen  [BEATS];
    logic [RAW_WIDTH-1:0]  m_raw   [BEATS];
    logic                  m_valid;
    logic [LINE_WIDTH-1:0] m_line;
    logic                  m_comp;
    logic [LEN_W-1:0]      m_len;
    logic                  exp_ready;

    int num_checks = 0;
    int num_errors = 0;

    task automatic compareVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt   = 0;
        m_valid = 1'b0;
        m_line  = '0;
        m_comp  = 1'b0;
        m_len   = '0;
    endtask

    // Build the finished line from the whole list of beats: compressed if the lengths fit, else raw.
    task automatic modelCloseLine();
        int sum;
        int pos;
        sum = 0;
        for (int b = 0; b < BEATS; b++) sum += m_clen[b];
        m_line = '0;
        if (sum > LINE_WIDTH) begin
            for (int b = 0; b < BEATS; b++) m_line[b*RAW_WIDTH +: RAW_WIDTH] = m_raw[b];
            m_comp = 1'b0;
            m_len  = LEN_W'(LINE_WIDTH);
        end else begin
            pos = 0;
            for (int b = 0; b < BEATS; b++) begin
                for (int k = 0; k < m_clen[b]; k++) m_line[pos + k] = m_cdata[b][k];
                pos += m_clen[b];
            end
            m_comp = 1'b1;
            m_len  = LEN_W'(sum);
        end
        m_valid = 1'b1;
    endtask

    // Advance the model across one clock edge given the inputs currently driven.
    task automatic modelStep();
        logic drain;
        logic loaded;
        drain  = m_valid && i_ready;
        loaded = 1'b0;
        if (i_flush) begin
            m_cnt = 0;
        end else if (i_valid && exp_ready) begin
            m_cdata[m_cnt] = i_cdata;
            m_clen[m_cnt]  = int'(i_clen);
            m_raw[m_cnt]   = i_raw;
            if (m_cnt == BEATS - 1) begin
                modelCloseLine();
                loaded = 1'b1;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        if (!loaded && drain) m_valid = 1'b0;
    endtask

    task automatic checkOutput();
        exp_ready = !i_flush && (m_cnt != BEATS - 1 || !m_valid || i_ready);
        compareVal("o_ready", 128'(o_ready), 128'(exp_ready));
        compareVal("o_valid", 128'(o_valid), 128'(m_valid));
        if (m_valid) begin
            compareVal("o_line", o_line, m_line);
            compareVal("o_comp", 128'(o_comp), 128'(m_comp));
            compareVal("o_len", 128'(o_len), 128'(m_len));
        end
    endtask

    // One cycle: drive inputs after the falling edge, check outputs, then advance the model.
    task automatic applyStimulus(input logic v, input logic [CDATA_W-1:0] cd, input int cl,
                                 input logic [RAW_WIDTH-1:0] raw, input logic fl, input logic rdy);
        @(negedge clk);
        i_valid = v;
        i_cdata = cd;
        i_clen  = CLEN_W'(cl);
        i_raw   = raw;
        i_flush = fl;
        i_ready = rdy;
        #1;
        checkOutput();
        modelStep();
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, '0, 0, '0, 1'b0, rdy);
    endtask

    task automatic checkAllZero(input string tag);
        compareVal({tag, "_valid"}, 128'(o_valid), 128'(0));
        compareVal({tag, "_line"}, o_line, 128'(0));
        compareVal({tag, "_comp"}, 128'(o_comp), 128'(0));
        compareVal({tag, "_len"}, 128'(o_len), 128'(0));
    endtask

    logic [95:0] rnd_wide;
    logic [CDATA_W-1:0] rnd_cd;
    logic [RAW_WIDTH-1:0] rnd_raw;
    int rnd_cl;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_cdata = '0;
        i_clen  = '0;
        i_raw   = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        compareVal("reset_ready", 128'(o_ready), 128'(1));
        i_reset = 1'b0;

        $display("[TB] two-beat compressed line");
        applyStimulus(1'b1, 68'hABCDE, 20, 64'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 68'h3FFFFFFF, 30, 64'hBBBB, 1'b0, 1'b0);
        idle(1'b0);
        compareVal("t1_valid", 128'(o_valid), 128'(1));
        compareVal("t1_comp", 128'(o_comp), 128'(1));
        compareVal("t1_len", 128'(o_len), 128'(50));
        compareVal("t1_line", o_line, 128'h3FFFFFFFABCDE);
        idle(1'b1);

        $display("[TB] overflow to raw line");
        applyStimulus(1'b1, '1, 68, 64'h1111111111111111, 1'b0, 1'b1);
        applyStimulus(1'b1, '1, 68, 64'h2222222222222222, 1'b0, 1'b1);
        idle(1'b0);
        compareVal("t2_comp", 128'(o_comp), 128'(0));
        compareVal("t2_len", 128'(o_len), 128'(128));
        compareVal("t2_line", o_line, 128'h22222222222222221111111111111111);
        idle(1'b1);

        $display("[TB] exact fit and one bit over");
        applyStimulus(1'b1, 68'hF_0123456789ABCDEF, 64, 64'h3, 1'b0, 1'b1);
        applyStimulus(1'b1, 68'hF_FEDCBA9876543210, 64, 64'h4, 1'b0, 1'b1);
        idle(1'b0);
        compareVal("t3_comp", 128'(o_comp), 128'(1));
        compareVal("t3_len", 128'(o_len), 128'(128));
        compareVal("t3_line", o_line, 128'hFEDCBA98765432100123456789ABCDEF);
        applyStimulus(1'b1, 68'h5, 64, 64'h5555, 1'b0, 1'b1);
        applyStimulus(1'b1, 68'h6, 65, 64'h6666, 1'b0, 1'b1);
        idle(1'b0);
        compareVal("t3b_comp", 128'(o_comp), 128'(0));
        compareVal("t3b_line", o_line, {64'h6666, 64'h5555});
        idle(1'b1);

        $display("[TB] backpressure on closing beat");
        applyStimulus(1'b1, 68'h3FF, 10, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 68'h155, 10, 64'h0, 1'b0, 1'b0);
        idle(1'b0);
        applyStimulus(1'b1, 68'hFFF, 12, 64'h0, 1'b0, 1'b0);
        compareVal("bp_open_ready", 128'(o_ready), 128'(1));
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 68'hABC, 12, 64'h0, 1'b0, 1'b0);
            compareVal("bp_stall_ready", 128'(o_ready), 128'(0));
            compareVal("bp_hold_len", 128'(o_len), 128'(20));
            compareVal("bp_hold_line", o_line, 128'h557FF);
        end
        applyStimulus(1'b1, 68'hABC, 12, 64'h0, 1'b0, 1'b1);
        idle(1'b0);
        compareVal("bp_new_valid", 128'(o_valid), 128'(1));
        compareVal("bp_new_len", 128'(o_len), 128'(24));
        compareVal("bp_new_line", o_line, 128'hABCFFF);
        idle(1'b1);

        $display("[TB] flush mid-line");
        applyStimulus(1'b1, 68'hFF, 8, 64'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 68'hEE, 8, 64'h0, 1'b1, 1'b1);
        compareVal("flush_ready", 128'(o_ready), 128'(0));
        applyStimulus(1'b1, 68'hAA, 8, 64'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 68'h55, 8, 64'h0, 1'b0, 1'b1);
        idle(1'b0);
        compareVal("flush_len", 128'(o_len), 128'(16));
        compareVal("flush_line", o_line, 128'h55AA);
        idle(1'b1);

        $display("[TB] asynchronous reset mid-line");
        applyStimulus(1'b1, 68'h1, 4, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 68'h2, 4, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 68'h3, 4, 64'h0, 1'b0, 1'b0);
        i_valid = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        checkAllZero("arst");
        modelReset();
        @(negedge clk);
        i_reset = 1'b0;
        applyStimulus(1'b1, 68'hF, 4, 64'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 68'h3, 4, 64'h0, 1'b0, 1'b1);
        idle(1'b0);
        compareVal("arst_len", 128'(o_len), 128'(8));
        compareVal("arst_line", o_line, 128'h3F);
        idle(1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            rnd_wide = {$urandom(), $urandom(), $urandom()};
            rnd_cd   = rnd_wide[CDATA_W-1:0];
            rnd_raw  = {$urandom(), $urandom()};
            case ($urandom_range(0, 2))
                0:       rnd_cl = int'($urandom_range(0, 68));
                1:       rnd_cl = int'($urandom_range(58, 68));
                default: rnd_cl = int'($urandom_range(0, 20));
            endcase
            applyStimulus($urandom_range(0, 3) != 0, rnd_cd, rnd_cl, rnd_raw,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (4) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
